osc_sim: RTL and testbench

- Behavioural oscillator model: numerically controlled oscillator (NCO) that synthesises a free-running clock CKO from a fast reference clock.
- Used where a block needs its own asynchronous clock source (e.g. a camera pixel clock) independent of system clocks.
- Nominal frequency is set by parameter, trimmed at run time by CFG, gated by EN.

---
 rtl/osc_sim_nco.sv | 40 ++++
 rtl/osc_sim.sv | 69 ++++++
 tb/tb_osc_sim.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/osc_sim_nco.sv
// Phase accumulator and output flop of the oscillator. While run is high the
// phase advances by inc every reference edge; while low everything returns to 0.
module osc_sim_nco #(
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ACC_W-1:0] inc,
   input  logic             run,
   output logic             cko,
   output logic             next_msb
);

   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic             cko_q, cko_d;

   always_comb begin
      acc_sum  = acc_q + inc;
      next_msb = acc_sum[ACC_W-1];
      acc_d    = '0;
      cko_d    = 1'b0;
      if (run) begin
         acc_d = acc_sum;
         cko_d = acc_sum[ACC_W-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cko_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cko_q <= cko_d;
      end
   end

   assign cko = cko_q;

endmodule

// File: rtl/osc_sim.sv
// Numerically controlled oscillator: synthesises CKO from the reference clock,
// with a signed run-time trim and a glitch-free enable that finishes any high phase.
module osc_sim #(
   parameter int FREQ_MHZ = 80,
   parameter int REF_MHZ  = 800,
   parameter int CFG_W    = 8,
   parameter int ACC_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EN,
   input  logic [CFG_W-1:0] CFG,
   output logic             CKO
);

   localparam int TRIM_SHIFT = 10;
   localparam int PROD_W     = ACC_W + CFG_W + 1;
   localparam logic [ACC_W-1:0] INC_NOM =
      ACC_W'(((64'(FREQ_MHZ) << ACC_W) + 64'(REF_MHZ / 2)) / 64'(REF_MHZ));

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                   state_q, state_d;
   logic [ACC_W-1:0]         inc_q, inc_d;
   logic signed [PROD_W-1:0] nom_ext, cfg_ext, trim_prod, trim_delta;
   logic                     advance, cko, next_msb;

   // One CFG LSB scales the step by 1/1024 of nominal; the shift floors toward -inf.
   always_comb begin
      nom_ext    = $signed({{(CFG_W + 1){1'b0}}, INC_NOM});
      cfg_ext    = $signed({{(ACC_W + 1){CFG[CFG_W-1]}}, CFG});
      trim_prod  = nom_ext * cfg_ext;
      trim_delta = trim_prod >>> TRIM_SHIFT;
      inc_d      = INC_NOM + trim_delta[ACC_W-1:0];
   end

   // With EN low a high phase is allowed to run out so no runt pulse appears.
   always_comb begin
      advance = EN || ((state_q != IDLE) && cko && next_msb);
      state_d = IDLE;
      if (advance) begin
         state_d = EN ? RUN : DRAIN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         inc_q   <= INC_NOM;
      end else begin
         state_q <= state_d;
         inc_q   <= inc_d;
      end
   end

   osc_sim_nco #(
      .ACC_W(ACC_W)
   ) u_nco (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_q),
      .run     (advance),
      .cko     (cko),
      .next_msb(next_msb)
   );

   assign CKO = cko;

endmodule

// File: tb/tb_osc_sim.sv
// Self-checking bench for osc_sim: a phase-arithmetic reference model feeds a
// scoreboard queue, and a monitor compares CKO each cycle and gathers edge/phase statistics.
module tb_osc_sim;

   localparam longint INC_NOM_TB = 64'd429496730;
   localparam longint TWO32      = 64'd4294967296;
   localparam longint HALF       = 64'd2147483648;

   logic       clk;
   logic       rst;
   logic       EN;
   logic [7:0] CFG;
   logic       CKO;

   int checks = 0;
   int errors = 0;

   bit exp_q[$];

   int rises         = 0;
   bit prev_cko      = 1'b0;
   int seg_len       = 0;
   bit seg_valid     = 1'b0;
   int min_ph        = 1000;
   int max_ph        = 0;
   int last_high_len = 0;

   longint mdl_phase;
   longint mdl_inc;
   bit     mdl_run;
   bit     mdl_cko;

   osc_sim #(80) dut (
      .clk(clk),
      .rst(rst),
      .EN (EN),
      .CFG(CFG),
      .CKO(CKO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Step = nominal step scaled by (1 + cfg/1024), fraction floored toward -inf.
   function automatic longint trim_inc(input int cfg);
      longint p;
      longint q;
      p = INC_NOM_TB * cfg;
      q = p / 1024;
      if (p < 0 && (p % 1024) != 0) q = q - 1;
      return INC_NOM_TB + q;
   endfunction

   task automatic model_reset();
      mdl_phase = 0;
      mdl_inc   = INC_NOM_TB;
      mdl_run   = 1'b0;
      mdl_cko   = 1'b0;
   endtask

   // One reference cycle: drive inputs, predict CKO after the coming edge, let the edge pass.
   task automatic apply_stimulus(input bit en, input logic [7:0] cfg);
      longint nxt;
      bit     nhigh;
      @(negedge clk);
      EN  = en;
      CFG = cfg;
      nxt   = (mdl_phase + mdl_inc) % TWO32;
      nhigh = (nxt >= HALF);
      if (en || (mdl_run && mdl_cko && nhigh)) begin
         mdl_phase = nxt;
         mdl_cko   = nhigh;
         mdl_run   = 1'b1;
      end else begin
         mdl_phase = 0;
         mdl_cko   = 1'b0;
         mdl_run   = 1'b0;
      end
      mdl_inc = trim_inc(int'($signed(cfg)));
      exp_q.push_back(mdl_cko);
      @(posedge clk);
      #2;
   endtask

   task automatic check_output(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clear_stats();
      seg_valid = 1'b0;
      min_ph    = 1000;
      max_ph    = 0;
   endtask

   task automatic go_idle(input logic [7:0] cfg);
      for (int i = 0; i < 30 && mdl_run; i++) apply_stimulus(1'b0, cfg);
      repeat (2) apply_stimulus(1'b0, cfg);
   endtask

   task automatic run_window(input string name, input logic [7:0] cfg, input int n,
                             input int lo, input int hi, input int ph_lo, input int ph_hi);
      int r0;
      go_idle(cfg);
      clear_stats();
      r0 = rises;
      repeat (n) apply_stimulus(1'b1, cfg);
      check_output({name, "_rises"}, rises - r0, lo, hi);
      check_output({name, "_min_phase"}, min_ph, ph_lo, 1000);
      check_output({name, "_max_phase"}, max_ph, 0, ph_hi);
   endtask

   // Monitor: scoreboard compare plus rising-edge and phase-length bookkeeping.
   initial begin
      bit e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (CKO !== e) begin
               errors++;
               $display("[TB] FAIL cko_scoreboard t=%0t: CKO=%0b required %0b", $time, CKO, e);
            end
         end
         if (CKO === 1'b1 && prev_cko == 1'b0) rises++;
         if (CKO !== prev_cko) begin
            if (seg_valid) begin
               if (seg_len < min_ph) min_ph = seg_len;
               if (seg_len > max_ph) max_ph = seg_len;
               if (prev_cko) last_high_len = seg_len;
            end
            seg_valid = 1'b1;
            seg_len   = 1;
         end else begin
            seg_len++;
         end
         prev_cko = (CKO === 1'b1);
      end
   end

   initial begin
      int         r0;
      int         n;
      logic [7:0] cfg;
      bit         en;

      rst = 1'b1;
      EN  = 1'b0;
      CFG = 8'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check_output("reset_cko", CKO, 0, 0);
      rst = 1'b0;
      $display("[TB] reset released");

      r0 = rises;
      repeat (100) apply_stimulus(1'b0, 8'd0);
      check_output("idle_after_reset_rises", rises - r0, 0, 0);

      run_window("nominal", 8'd0, 1000, 99, 101, 4, 6);
      run_window("trim_p64", 8'd64, 2000, 212, 213, 4, 6);
      run_window("trim_m64", 8'hC0, 2000, 187, 188, 4, 6);
      run_window("trim_p127", 8'd127, 2000, 224, 225, 3, 7);
      run_window("trim_m128", 8'h80, 2000, 174, 175, 3, 7);

      // Gate while high: drop EN one cycle after a rise; high phase must complete.
      go_idle(8'd0);
      clear_stats();
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, 8'd0);
         if (CKO === 1'b1) break;
      end
      check_output("gate_rise_seen", CKO, 1, 1);
      apply_stimulus(1'b1, 8'd0);
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b0, 8'd0);
         if (CKO === 1'b0) break;
      end
      check_output("gate_fall_seen", CKO, 0, 0);
      check_output("gate_high_len", last_high_len, 5, 5);
      r0 = rises;
      repeat (20) apply_stimulus(1'b0, 8'd0);
      check_output("gate_stays_low", rises - r0, 0, 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, 8'd0);
         n++;
         if (CKO === 1'b1) break;
      end
      check_output("reenable_first_rise", n, 1, 6);

      // CFG steps from 0 to +64 in the middle of a high phase.
      go_idle(8'd0);
      repeat (2) apply_stimulus(1'b1, 8'd0);
      clear_stats();
      repeat (7) apply_stimulus(1'b1, 8'd0);
      repeat (200) apply_stimulus(1'b1, 8'd64);
      check_output("cfg_step_min_phase", min_ph, 4, 1000);

      // Randomised enable toggling and trim changes.
      en  = 1'b1;
      cfg = 8'd0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) en = ~en;
         if ($urandom_range(0, 99) == 0) cfg = 8'($urandom_range(0, 255));
         apply_stimulus(en, cfg);
      end

      // Asynchronous reset while CKO is high and EN still asserted.
      go_idle(8'd0);
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, 8'd0);
         if (CKO === 1'b1) break;
      end
      check_output("pre_reset_high", CKO, 1, 1);
      #1;
      rst = 1'b1;
      #1;
      check_output("async_reset_cko", CKO, 0, 0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      EN  = 1'b0;
      rst = 1'b0;
      r0 = rises;
      repeat (100) apply_stimulus(1'b0, 8'd0);
      check_output("idle_after_midreset_rises", rises - r0, 0, 0);
      check_output("scoreboard_drained", exp_q.size(), 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
